// File: rtl/rf_bypass_2w_if.sv
// Register-file access bundle: two read selects, two write ports, error flags.
// The decode stage drives through master; the register file sits on slave.
interface rf_bypass_2w_if #(
  parameter int WIDTH = 16,
  parameter int SELW  = 3
);
  logic [SELW-1:0]  read1regsel;
  logic [SELW-1:0]  read2regsel;
  logic [SELW-1:0]  write0regsel;
  logic [WIDTH-1:0] write0data;
  logic             write0;
  logic [SELW-1:0]  write1regsel;
  logic [WIDTH-1:0] write1data;
  logic             write1;
  logic [WIDTH-1:0] read1data;
  logic [WIDTH-1:0] read2data;
  logic             err;
  logic             err_sticky;

  modport master (
    output read1regsel, read2regsel,
    output write0regsel, write0data, write0,
    output write1regsel, write1data, write1,
    input  read1data, read2data, err, err_sticky
  );

  modport slave (
    input  read1regsel, read2regsel,
    input  write0regsel, write0data, write0,
    input  write1regsel, write1data, write1,
    output read1data, read2data, err, err_sticky
  );
endinterface

// File: rtl/rf_bypass_2w.sv
// Two-write / two-read register file with optional same-cycle bypass,
// optional hardwired zero register and range/conflict error reporting.
module rf_bypass_2w #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int SELW     = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input logic clk,
  input logic rst,
  rf_bypass_2w_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             sticky_q;
  logic             w0_hit;
  logic             w1_hit;
  logic             conflict;
  logic             err_c;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;

  function automatic logic ok(input logic [SELW-1:0] s);
    return 32'(s) < DEPTH;
  endfunction

  function automatic logic is_zero(input logic [SELW-1:0] s);
    return (ZERO_REG != 0) && (s == '0);
  endfunction

  // Port 1 is checked first so a forwarded value matches what gets stored.
  function automatic logic [WIDTH-1:0] rd(input logic [SELW-1:0] s);
    logic [WIDTH-1:0] v;
    v = '0;
    if (!ok(s))
      v = '0;
    else if (is_zero(s))
      v = '0;
    else if (BYPASS != 0 && bus.write1 && bus.write1regsel == s)
      v = bus.write1data;
    else if (BYPASS != 0 && bus.write0 && bus.write0regsel == s)
      v = bus.write0data;
    else
      v = regs[s[AW-1:0]];
    return v;
  endfunction

  always_comb begin
    w0_hit = bus.write0 && ok(bus.write0regsel)
             && !is_zero(bus.write0regsel);
    w1_hit = bus.write1 && ok(bus.write1regsel)
             && !is_zero(bus.write1regsel);
    conflict = bus.write0 && bus.write1
               && (bus.write0regsel == bus.write1regsel)
               && ok(bus.write0regsel);
    err_c = conflict
            || (bus.write0 && !ok(bus.write0regsel))
            || (bus.write1 && !ok(bus.write1regsel))
            || !ok(bus.read1regsel)
            || !ok(bus.read2regsel);
    rd1 = rd(bus.read1regsel);
    rd2 = rd(bus.read2regsel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      sticky_q <= 1'b0;
    end else begin
      if (w0_hit)
        regs[bus.write0regsel[AW-1:0]] <= bus.write0data;
      if (w1_hit)
        regs[bus.write1regsel[AW-1:0]] <= bus.write1data;
      sticky_q <= sticky_q | err_c;
    end
  end

  assign bus.read1data  = rst ? '0 : rd1;
  assign bus.read2data  = rst ? '0 : rd2;
  assign bus.err        = rst ? 1'b0 : err_c;
  assign bus.err_sticky = sticky_q;
endmodule

// File: tb/tb_rf_bypass_2w.sv
// Bench: one stimulus stream drives three instances (bypass, no bypass,
// DEPTH=6 with zero register); expectations are queued and checked at negedge.
module tb_rf_bypass_2w;
  logic clk = 1'b0;
  logic rst;
  logic [2:0]  r1, r2, w0s, w1s;
  logic [15:0] w0d, w1d;
  logic        w0, w1;

  always #5 clk = ~clk;

  rf_bypass_2w_if #(.WIDTH(16), .SELW(3)) b0 ();
  rf_bypass_2w_if #(.WIDTH(16), .SELW(3)) b1 ();
  rf_bypass_2w_if #(.WIDTH(16), .SELW(3)) b2 ();

  assign b0.read1regsel = r1;  assign b1.read1regsel = r1;  assign b2.read1regsel = r1;
  assign b0.read2regsel = r2;  assign b1.read2regsel = r2;  assign b2.read2regsel = r2;
  assign b0.write0regsel = w0s; assign b1.write0regsel = w0s; assign b2.write0regsel = w0s;
  assign b0.write0data = w0d;  assign b1.write0data = w0d;  assign b2.write0data = w0d;
  assign b0.write0 = w0;       assign b1.write0 = w0;       assign b2.write0 = w0;
  assign b0.write1regsel = w1s; assign b1.write1regsel = w1s; assign b2.write1regsel = w1s;
  assign b0.write1data = w1d;  assign b1.write1data = w1d;  assign b2.write1data = w1d;
  assign b0.write1 = w1;       assign b1.write1 = w1;       assign b2.write1 = w1;

  rf_bypass_2w #(.WIDTH(16), .DEPTH(8), .SELW(3), .BYPASS(1), .ZERO_REG(0))
    d0 (.clk(clk), .rst(rst), .bus(b0));
  rf_bypass_2w #(.WIDTH(16), .DEPTH(8), .SELW(3), .BYPASS(0), .ZERO_REG(0))
    d1 (.clk(clk), .rst(rst), .bus(b1));
  rf_bypass_2w #(.WIDTH(16), .DEPTH(6), .SELW(3), .BYPASS(1), .ZERO_REG(1))
    d2 (.clk(clk), .rst(rst), .bus(b2));

  typedef struct {
    int          id;
    int          kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  localparam int K_R1 = 0;
  localparam int K_R2 = 1;
  localparam int K_ERR = 2;
  localparam int K_STK = 3;

  function automatic logic [15:0] get(input int id, input int kind);
    logic [15:0] v;
    v = 'x;
    case (id)
      0: case (kind)
           K_R1: v = b0.read1data;
           K_R2: v = b0.read2data;
           K_ERR: v = {15'd0, b0.err};
           default: v = {15'd0, b0.err_sticky};
         endcase
      1: case (kind)
           K_R1: v = b1.read1data;
           K_R2: v = b1.read2data;
           K_ERR: v = {15'd0, b1.err};
           default: v = {15'd0, b1.err_sticky};
         endcase
      default: case (kind)
           K_R1: v = b2.read1data;
           K_R2: v = b2.read2data;
           K_ERR: v = {15'd0, b2.err};
           default: v = {15'd0, b2.err_sticky};
         endcase
    endcase
    return v;
  endfunction

  // Monitor: consumes every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [15:0] a;
      e = q.pop_front();
      a = get(e.id, e.kind);
      checks++;
      if (a !== e.val) begin
        errors++;
        $display("FAIL %s dut%0d: got %h expected %h",
                 e.name, e.id, a, e.val);
      end
    end
  end

  task automatic ex3(input int kind, input logic [15:0] v0,
                     input logic [15:0] v1, input logic [15:0] v2,
                     input string name);
    q.push_back('{0, kind, v0, name});
    q.push_back('{1, kind, v1, name});
    q.push_back('{2, kind, v2, name});
  endtask

  task automatic drive(input logic rs, input logic [2:0] a1,
                       input logic [2:0] a2,
                       input logic e0, input logic [2:0] s0,
                       input logic [15:0] d0v,
                       input logic e1, input logic [2:0] s1,
                       input logic [15:0] d1v);
    rst = rs; r1 = a1; r2 = a2;
    w0 = e0; w0s = s0; w0d = d0v;
    w1 = e1; w1s = s1; w1d = d1v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 1, 3, 16'h1111, 0, 0, 0);
    #1;
    ex3(K_R1, 0, 0, 0, "rst_r1");
    ex3(K_R2, 0, 0, 0, "rst_r2");
    ex3(K_ERR, 0, 0, 0, "rst_err");
    step();
    ex3(K_R1, 0, 0, 0, "rst2_r1");
    ex3(K_ERR, 0, 0, 0, "rst2_err");
    ex3(K_STK, 0, 0, 0, "rst_sticky");
    step();

    drive(0, 3, 3, 1, 3, 16'hBEEF, 0, 0, 0);
    ex3(K_R1, 16'hBEEF, 0, 16'hBEEF, "wr3_r1");
    ex3(K_ERR, 0, 0, 0, "wr3_err");
    step();

    drive(0, 5, 5, 1, 5, 16'h1234, 0, 0, 0);
    ex3(K_R1, 16'h1234, 0, 16'h1234, "byp5_r1");
    ex3(K_R2, 16'h1234, 0, 16'h1234, "byp5_r2");
    step();

    drive(0, 3, 5, 0, 0, 0, 0, 0, 0);
    ex3(K_R1, 16'hBEEF, 16'hBEEF, 16'hBEEF, "rd3");
    ex3(K_R2, 16'h1234, 16'h1234, 16'h1234, "rd5");
    ex3(K_ERR, 0, 0, 0, "rd_err");
    ex3(K_STK, 0, 0, 0, "sticky_clear");
    step();

    drive(0, 2, 3, 1, 2, 16'hAAAA, 1, 2, 16'h5555);
    ex3(K_R1, 16'h5555, 0, 16'h5555, "conf_r1");
    ex3(K_R2, 16'hBEEF, 16'hBEEF, 16'hBEEF, "conf_r2");
    ex3(K_ERR, 1, 1, 1, "conf_err");
    step();

    drive(0, 2, 2, 0, 0, 0, 0, 0, 0);
    ex3(K_R1, 16'h5555, 16'h5555, 16'h5555, "conf_store");
    ex3(K_ERR, 0, 0, 0, "conf_next_err");
    ex3(K_STK, 1, 1, 1, "conf_sticky");
    step();

    drive(0, 1, 6, 1, 1, 16'h0011, 1, 6, 16'h0066);
    ex3(K_R1, 16'h0011, 0, 16'h0011, "dual_r1");
    ex3(K_R2, 16'h0066, 0, 0, "dual_r2");
    ex3(K_ERR, 0, 0, 1, "dual_err");
    step();

    drive(0, 1, 6, 0, 0, 0, 0, 0, 0);
    ex3(K_R1, 16'h0011, 16'h0011, 16'h0011, "dual_rd1");
    ex3(K_R2, 16'h0066, 16'h0066, 0, "dual_rd6");
    ex3(K_ERR, 0, 0, 1, "rd6_err");
    step();

    drive(0, 7, 4, 1, 7, 16'h7777, 0, 0, 0);
    ex3(K_R1, 16'h7777, 0, 0, "wr7_r1");
    ex3(K_R2, 0, 0, 0, "wr7_r2");
    ex3(K_ERR, 0, 0, 1, "wr7_err");
    step();

    drive(0, 7, 3, 0, 0, 0, 0, 0, 0);
    ex3(K_R1, 16'h7777, 16'h7777, 0, "rd7");
    ex3(K_R2, 16'hBEEF, 16'hBEEF, 16'hBEEF, "rd3_after");
    ex3(K_ERR, 0, 0, 1, "rd7_err");
    step();

    drive(0, 0, 0, 1, 0, 16'hFFFF, 0, 0, 0);
    ex3(K_R1, 16'hFFFF, 0, 0, "wr0_r1");
    ex3(K_ERR, 0, 0, 0, "wr0_err");
    step();

    drive(0, 0, 5, 0, 0, 0, 0, 0, 0);
    ex3(K_R1, 16'hFFFF, 16'hFFFF, 0, "rd0");
    ex3(K_R2, 16'h1234, 16'h1234, 16'h1234, "rd5_again");
    step();

    drive(0, 5, 2, 0, 7, 16'hDEAD, 0, 6, 16'hDEAD);
    ex3(K_R1, 16'h1234, 16'h1234, 16'h1234, "dis_r1");
    ex3(K_R2, 16'h5555, 16'h5555, 16'h5555, "dis_r2");
    ex3(K_ERR, 0, 0, 0, "dis_err");
    step();

    drive(0, 4, 4, 0, 0, 0, 1, 4, 16'h4040);
    ex3(K_R1, 16'h4040, 0, 16'h4040, "w1_byp");
    ex3(K_ERR, 0, 0, 0, "w1_err");
    step();

    drive(1, 4, 3, 1, 4, 16'h4444, 0, 0, 0);
    ex3(K_R1, 0, 0, 0, "mid_rst_r1");
    ex3(K_R2, 0, 0, 0, "mid_rst_r2");
    ex3(K_STK, 1, 1, 1, "pre_rst_sticky");
    step();

    drive(0, 4, 3, 0, 0, 0, 0, 0, 0);
    ex3(K_R1, 0, 0, 0, "post_rst_r4");
    ex3(K_R2, 0, 0, 0, "post_rst_r3");
    ex3(K_STK, 0, 0, 0, "post_rst_sticky");
    ex3(K_ERR, 0, 0, 0, "post_rst_err");

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d pending, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rf_bypass_2w.md
Name: rf_bypass_2w

Overview:
- Parametrised register file with two write ports and two read ports. Write-before-read bypass on both read ports, selectable per instance.
- Successor to the single-write-port 8x16 bypass register file. Generalises width and depth and adds:
  - a second write port with a fixed priority rule,
  - an optional hardwired zero register,
  - out-of-range and write-conflict detection, with a sticky error flag.
- Sits in the decode stage of the pipelined datapath. Write port 0 serves writeback; write port 1 serves a second retiring result (e.g. load or link).

Parameters:
- WIDTH, 16, data width of every register and data port
- DEPTH, 8, number of registers; need not be a power of two
- SELW, 3, register-select width; must satisfy 2**SELW >= DEPTH
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- read1regsel  in  SELW  read port 1 register select
- read2regsel  in  SELW  read port 2 register select
- write0regsel  in  SELW  write port 0 register select
- write0data  in  WIDTH  write port 0 data
- write0  in  1  write port 0 enable
- write1regsel  in  SELW  write port 1 register select
- write1data  in  WIDTH  write port 1 data
- write1  in  1  write port 1 enable
- read1data  out  WIDTH  read port 1 data, combinational
- read2data  out  WIDTH  read port 2 data, combinational
- err  out  1  current-cycle error, combinational
- err_sticky  out  1  registered; set on any cycle with err=1, cleared only by rst

Behaviour:
- Reset: clock is clk; reset is rst, synchronous and active-high.
  - On a rising edge with rst=1, all DEPTH registers load 0 and err_sticky loads 0.
  - Writes presented in that cycle are discarded.
  - While rst=1, read1data, read2data and err are driven 0.
- Write: on a rising edge with rst=0, each enabled port with regsel < DEPTH updates its register.
  - Out-of-range write selects are ignored; storage is unchanged.
- Write conflict (write0=write1=1, equal in-range selects):
  - write1data is stored; port 1 wins.
  - err=1 for that cycle.
- ZERO_REG=1:
  - writes to register 0 are dropped without error;
  - reads of register 0 return 0 and are never bypassed.
- Read value (rst=0), for each read port independently, in priority order:
  1. select >= DEPTH -> 0, and err=1.
  2. ZERO_REG=1 and select==0 -> 0.
  3. BYPASS=1, write1=1, write1regsel==select -> write1data.
  4. BYPASS=1, write0=1, write0regsel==select -> write0data.
  5. Otherwise -> stored register value.
  - Bypass priority matches the storage priority, so the bypassed value always equals the value stored at the next edge.
- BYPASS=0: a read of a register being written returns the old value that cycle and the new value from the next cycle on. Zero-cycle read latency either way.
- err (rst=0) = OR of:
  - write conflict;
  - enabled write with select >= DEPTH;
  - either read select >= DEPTH.
  - Disabled write ports never raise err. err is combinational and not registered.
- err_sticky:
  - next = rst ? 0 : (err_sticky | err);
  - visible one cycle after the error cycle; holds until rst.
- No X-propagation reliance: all outputs are defined for all in-range and out-of-range selects.
- Storage is a flat array of DEPTH x WIDTH flops. No read-side registers.

Test Plan:
- Reset/readback (DEPTH=8, WIDTH=16, BYPASS=1): assert rst 2 cycles with write0=1 -> all reads 0, err=0, err_sticky=0. Then write reg3=16'hBEEF via port 0, read reg3 next cycle -> 16'hBEEF.
- Bypass: write0 reg5=16'h1234 and read1regsel=read2regsel=5 in the same cycle -> both reads 16'h1234 that cycle. Repeat with BYPASS=0 -> old value (0) that cycle, 16'h1234 the next.
- Conflict: write0 reg2=16'hAAAA and write1 reg2=16'h5555 same cycle, read1regsel=2 -> read1data=16'h5555, err=1. Next cycle: reg2 reads 16'h5555, err=0, err_sticky=1.
- Dual write: write0 reg1=16'h0011 and write1 reg6=16'h0066 same cycle, no conflict -> err=0. Next cycle reads: reg1=16'h0011, reg6=16'h0066.
- Range/zero (DEPTH=6, SELW=3, ZERO_REG=1):
  - write0 to reg7 -> err=1, no register changes.
  - read1regsel=6 -> read1data=0, err=1.
  - write reg0=16'hFFFF -> reg0 reads 0, err=0.
- Reset mid-operation: after writes and err_sticky=1, assert rst together with write0 reg4=16'h4444 -> next cycle reg4 reads 0 and err_sticky=0.
